// File: rtl/grid_cell_classifier.sv
// Grid cell classifier: accumulates window luma in each of the 8x8 board cells
// over one frame and publishes a thresholded occupancy map once per frame.
module grid_cell_classifier #(
    parameter int GRID_LEFT  = 155,
    parameter int GRID_TOP   = 46,
    parameter int PITCH_H    = 70,
    parameter int PITCH_V    = 72,
    parameter int SAMP_OFS_H = 19,
    parameter int SAMP_OFS_V = 16,
    parameter int SAMP_LOG2  = 5,
    parameter int V_EVAL     = GRID_TOP + 7 * PITCH_V + SAMP_OFS_V + (1 << SAMP_LOG2)
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iEnable,
    input  logic [12:0] iH_Cont,
    input  logic [12:0] iV_Cont,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    input  logic [9:0]  iThresh,
    output logic [63:0] oMap,
    output logic        oValid,
    output logic        oBusy
);
    localparam int WIN   = 1 << SAMP_LOG2;
    localparam int ACC_W = 20;

    typedef enum logic [2:0] {IDLE, WAIT_SOF, ACCUM, EVAL, DONE} state_t;

    function automatic logic [9:0] luma(input logic [9:0] r, input logic [9:0] g,
                                        input logic [9:0] b);
        logic [11:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[11:2];
    endfunction

    function automatic logic [12:0] col_lo(input int i);
        return 13'(GRID_LEFT + i * PITCH_H + SAMP_OFS_H);
    endfunction

    function automatic logic [12:0] row_lo(input int i);
        return 13'(GRID_TOP + i * PITCH_V + SAMP_OFS_V);
    endfunction

    state_t           state_q;
    logic [9:0]       y_p1_q;
    logic             vld_p1_q;
    logic [5:0]       cell_p1_q;
    logic [ACC_W-1:0] acc_q [64];
    logic [5:0]       idx_q;
    logic [9:0]       thr_q;
    logic [63:0]      res_q;
    logic [63:0]      res_d;

    logic [2:0] col_p0, row_p0;
    logic       col_hit_p0, row_hit_p0;
    logic       sof, eval_row, eval_bit;

    assign sof      = (iH_Cont == 13'd0) && (iV_Cont == 13'd0);
    assign eval_row = (iH_Cont == 13'd0) && (iV_Cont == 13'(V_EVAL));
    assign eval_bit = (acc_q[idx_q] >> (2 * SAMP_LOG2)) >= ACC_W'(thr_q);

    // Constant range compares per column/row; at most one can hit since windows never overlap.
    always_comb begin
        col_hit_p0 = 1'b0;
        col_p0     = 3'd0;
        row_hit_p0 = 1'b0;
        row_p0     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (iH_Cont >= col_lo(i) && iH_Cont < col_lo(i) + 13'(WIN)) begin
                col_hit_p0 = 1'b1;
                col_p0     = 3'(i);
            end
            if (iV_Cont >= row_lo(i) && iV_Cont < row_lo(i) + 13'(WIN)) begin
                row_hit_p0 = 1'b1;
                row_p0     = 3'(i);
            end
        end
    end

    always_comb begin
        res_d        = res_q;
        res_d[idx_q] = eval_bit;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= IDLE;
            y_p1_q    <= '0;
            vld_p1_q  <= 1'b0;
            cell_p1_q <= '0;
            for (int i = 0; i < 64; i++) acc_q[i] <= '0;
            idx_q     <= '0;
            thr_q     <= '0;
            res_q     <= '0;
            oMap      <= '0;
            oValid    <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            // Stage 1: luma and window decode
            y_p1_q    <= luma(iRed, iGreen, iBlue);
            vld_p1_q  <= col_hit_p0 && row_hit_p0 && !(state_q == WAIT_SOF && sof);
            cell_p1_q <= {row_p0, col_p0};
            // Stage 2: accumulate into the addressed cell
            if (vld_p1_q && state_q == ACCUM)
                acc_q[cell_p1_q] <= acc_q[cell_p1_q] + ACC_W'(y_p1_q);

            oValid <= 1'b0;
            case (state_q)
                IDLE: if (iEnable) state_q <= WAIT_SOF;
                WAIT_SOF: begin
                    if (!iEnable) begin
                        state_q <= IDLE;
                    end else if (sof) begin
                        for (int i = 0; i < 64; i++) acc_q[i] <= '0;
                        state_q <= ACCUM;
                        oBusy   <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (eval_row) begin
                        thr_q   <= iThresh;
                        idx_q   <= '0;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    res_q <= res_d;
                    idx_q <= idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        oMap    <= res_d;
                        oValid  <= 1'b1;
                        oBusy   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= iEnable ? WAIT_SOF : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grid_cell_classifier.sv
// Scoreboard bench for grid_cell_classifier using a compact grid geometry so
// that whole frames fit in a short run.
module tb_grid_cell_classifier;
    localparam int GL = 4, GT = 3, PH = 10, PV = 8, OH = 2, OV = 2, SL = 2;
    localparam int WIN   = 1 << SL;
    localparam int VE    = 65;
    localparam int HW    = 84;
    localparam int VROWS = VE + 2;
    localparam int M_UNI = 0, M_CELL = 1, M_BOUND = 2, M_RAND = 3, M_PCELL = 4;

    typedef struct {
        logic [63:0] map;
        int          cyc;
    } exp_t;

    logic        iCLK = 1'b0;
    logic        iRST_N, iEnable;
    logic [12:0] iH_Cont, iV_Cont;
    logic [9:0]  iRed, iGreen, iBlue, iThresh;
    logic [63:0] oMap;
    logic        oValid, oBusy;

    grid_cell_classifier #(
        .GRID_LEFT(GL), .GRID_TOP(GT), .PITCH_H(PH), .PITCH_V(PV),
        .SAMP_OFS_H(OH), .SAMP_OFS_V(OV), .SAMP_LOG2(SL), .V_EVAL(VE)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEnable(iEnable),
        .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iThresh(iThresh),
        .oMap(oMap), .oValid(oValid), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    int   cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    exp_t q[$];
    int   n_vec = 0, n_err = 0;
    bit   expect_idle = 0, end_req = 0;
    int   base_m [64];

    // Cell owning pixel (x,y), or -1 when outside every sample window.
    function automatic int cell_of(input int x, input int y);
        int dx, dy;
        dx = x - GL - OH;
        dy = y - GT - OV;
        if (dx < 0 || dy < 0) return -1;
        if (dx / PH > 7 || dy / PV > 7) return -1;
        if (dx % PH >= WIN || dy % PV >= WIN) return -1;
        return (dy / PV) * 8 + dx / PH;
    endfunction

    task automatic pix(input int mode, input int x, input int y,
                       output int rr, output int gg, output int bb);
        int c, rx, ry, v;
        c  = cell_of(x, y);
        rx = ((x - GL - OH) % PH + PH) % PH;
        ry = ((y - GT - OV) % PV + PV) % PV;
        case (mode)
            M_UNI:   v = 512;
            M_CELL:  v = (c == 21) ? 1023 : 0;
            M_BOUND: v = (rx == PH - 1 || rx == WIN || ry == PV - 1 || ry == WIN) ? 1023 : 0;
            M_PCELL: v = (c >= 0) ? (base_m[c] ^ int'($urandom_range(0, 7))) : int'($urandom_range(0, 1023));
            default: v = -1;
        endcase
        if (v < 0) begin
            rr = $urandom_range(0, 1023);
            gg = $urandom_range(0, 1023);
            bb = $urandom_range(0, 1023);
        end else begin
            rr = v; gg = v; bb = v;
        end
    endtask

    task automatic frame(input int mode, input int th, input bit use_const,
                         input logic [63:0] cmap, input bit publish,
                         input int rst_idx, input bit drop_en);
        int          sum [64];
        int          rr, gg, bb, c, eval_cyc;
        bit          seen;
        logic [63:0] emap;
        exp_t        e;
        seen = 0;
        eval_cyc = 0;
        emap = '0;
        for (int i = 0; i < 64; i++) begin
            sum[i]    = 0;
            base_m[i] = $urandom_range(0, 1023);
        end
        iThresh = 10'(th);
        repeat (2) begin
            @(posedge iCLK); #1;
            iH_Cont = '1; iV_Cont = '1; iRed = '0; iGreen = '0; iBlue = '0;
        end
        for (int y = 0; y < VROWS; y++) begin
            if (drop_en && y == VE / 2) iEnable = 1'b0;
            if (mode == M_RAND && y == 20) begin
                @(posedge iCLK); #1;
                iH_Cont = '0; iV_Cont = '0; iRed = '1; iGreen = '1; iBlue = '1;
            end
            for (int x = 0; x < HW; x++) begin
                @(posedge iCLK); #1;
                pix(mode, x, y, rr, gg, bb);
                iH_Cont = 13'(x); iV_Cont = 13'(y);
                iRed = 10'(rr); iGreen = 10'(gg); iBlue = 10'(bb);
                c = cell_of(x, y);
                if (c >= 0) sum[c] += (rr + 2 * gg + bb) / 4;
                if (y == VE && x == 0) begin
                    seen     = 1;
                    eval_cyc = cyc;
                    for (int i = 0; i < 64; i++) emap[i] = ((sum[i] / (WIN * WIN)) >= th);
                    if (publish) begin
                        e.map = use_const ? cmap : emap;
                        e.cyc = cyc + 65;
                        q.push_back(e);
                    end
                end
                if (y == VE && x == 1) iThresh = 10'($urandom_range(0, 1023));
                if (seen && rst_idx >= 0 && cyc == eval_cyc + 1 + rst_idx) iRST_N = 1'b0;
                if (seen && rst_idx >= 0 && cyc == eval_cyc + 4 + rst_idx) iRST_N = 1'b1;
            end
        end
    endtask

    always @(negedge iCLK) begin
        exp_t e;
        if (!iRST_N) begin
            n_vec++;
            if (oMap !== 64'd0 || oValid !== 1'b0 || oBusy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs map=%h valid=%b busy=%b required 0/0/0", oMap, oValid, oBusy);
            end
        end else begin
            if (expect_idle) begin
                n_vec++;
                if (oBusy !== 1'b0 || oValid !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_after_disable busy=%b valid=%b required 0/0", oBusy, oValid);
                end
            end
            if (q.size() > 0 && cyc == q[0].cyc - 1) begin
                n_vec++;
                if (oBusy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_in_eval busy=%b required 1", oBusy);
                end
            end
            if (oValid === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_valid at cycle %0d map=%h", cyc, oMap);
                end else begin
                    e = q.pop_front();
                    n_vec++;
                    if (oMap !== e.map) begin
                        n_err++;
                        $display("FAIL map got=%h required=%h", oMap, e.map);
                    end
                    n_vec++;
                    if (cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL valid_latency got cycle %0d required %0d", cyc, e.cyc);
                    end
                    n_vec++;
                    if (oBusy !== 1'b0) begin
                        n_err++;
                        $display("FAIL busy_in_done busy=%b required 0", oBusy);
                    end
                end
            end else if (q.size() > 0 && cyc >= q[0].cyc) begin
                e = q.pop_front();
                n_vec++; n_err++;
                $display("FAIL missing_valid by cycle %0d required map=%h", e.cyc, e.map);
            end
        end
        if (end_req) begin
            n_vec++;
            if (q.size() != 0) begin
                n_err++;
                $display("FAIL pending_results got %0d outstanding required 0", q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        iRST_N = 1'b0; iEnable = 1'b0;
        iH_Cont = '1; iV_Cont = '1;
        iRed = '0; iGreen = '0; iBlue = '0; iThresh = '0;
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1'b1;
        iEnable = 1'b1;
        frame(M_UNI,   500,  1, '1,          1, -1, 0);
        frame(M_UNI,   513,  1, '0,          1, -1, 0);
        frame(M_BOUND, 1,    1, '0,          1, -1, 0);
        frame(M_CELL,  1000, 1, 64'h1 << 21, 1, -1, 0);
        frame(M_UNI,   512,  1, '1,          1, -1, 0);
        frame(M_PCELL, $urandom_range(0, 1023), 0, '0, 0, 30, 0);
        frame(M_RAND,  $urandom_range(470, 550), 0, '0, 1, -1, 0);
        frame(M_PCELL, $urandom_range(0, 1023), 0, '0, 1, -1, 0);
        frame(M_PCELL, $urandom_range(0, 1023), 0, '0, 1, -1, 1);
        expect_idle = 1'b1;
        frame(M_UNI,   500,  1, '0,          0, -1, 0);
        expect_idle = 1'b0;
        repeat (4) @(posedge iCLK);
        #1 end_req = 1'b1;
    end
endmodule

// File: doc/grid_cell_classifier.md
Name: grid_cell_classifier

Overview:
- Sits downstream of the VGA timing controller. Taps the same pixel stream that feeds the display: active-area coordinates plus 10-bit RGB.
- Over one frame, accumulates luma inside a fixed square sample window in each of the 8x8 board cells.
- At a fixed row near frame end, compares each cell's mean luma against a threshold. Publishes a 64-bit occupancy map to the game logic with a one-cycle valid pulse.

Parameters:
- GRID_LEFT, 155: x of column-0 cell origin, in active-area coordinates.
- GRID_TOP, 46: y of row-0 cell origin.
- PITCH_H, 70: cell pitch in x, in pixels.
- PITCH_V, 72: cell pitch in y, in lines.
- SAMP_OFS_H, 19: x offset of the sample window inside a cell.
- SAMP_OFS_V, 16: y offset of the sample window inside a cell.
- SAMP_LOG2, 5: sample window is 2^SAMP_LOG2 square (32x32 = 1024 samples).
- V_EVAL, 598: row that triggers evaluation. Default = GRID_TOP + 7*PITCH_V + SAMP_OFS_V + 32.

Ports:
- iCLK  in  1  pixel clock (40 MHz).
- iRST_N  in  1  asynchronous active-low reset.
- iEnable  in  1  arm classification of successive frames.
- iH_Cont  in  13  active-area x coordinate; wraps modulo 2^13 in blanking.
- iV_Cont  in  13  active-area y coordinate.
- iRed  in  10  pixel red, aligned with iH_Cont/iV_Cont.
- iGreen  in  10  pixel green.
- iBlue  in  10  pixel blue.
- iThresh  in  10  luma threshold.
- oMap  out  64  occupancy map; bit row*8+col = 1 means mean luma >= threshold.
- oValid  out  1  one-cycle pulse when oMap updates.
- oBusy  out  1  high in ACCUM and EVAL.

Behaviour:
- Reset (async, iRST_N low): state IDLE, oMap=0, oValid=0, oBusy=0, all 64 accumulators=0, pipeline regs=0, cell index=0.
- Luma: Y = (R + 2G + B) >> 2. Computed in 12 bits, result 10 bits, truncating.
- Window membership:
  - Column c: GRID_LEFT + c*PITCH_H + SAMP_OFS_H <= iH_Cont < that + 32.
  - Row r: same form with the V parameters.
  - Evaluated by constant compares over all 8 columns and 8 rows. No divider.
- Accumulation pipeline:
  - Stage 1 registers Y, in-window flag and cell index {r,c}.
  - Stage 2 adds Y into acc[{r,c}] when the flag is set and state==ACCUM.
  - Latency from pixel to accumulator: 2 cycles.
- Accumulators: 20 bits each. Max 1023*1024 = 1,047,552 < 2^20, so no saturation is needed.
- State machine:
  - IDLE: go to WAIT_SOF when iEnable=1.
  - WAIT_SOF: when iH_Cont==0 && iV_Cont==0, clear all accumulators and the stage-1 valid flag, then go to ACCUM.
  - ACCUM: when iV_Cont==V_EVAL && iH_Cont==0, latch iThresh, set cell index=0, go to EVAL. The pipeline has long drained by then (last sample row is V_EVAL-1).
  - EVAL: one cell per cycle, 64 cycles. result[i] = (acc[i] >> (2*SAMP_LOG2)) >= latched thresh. After i=63, go to DONE.
  - DONE: one cycle. oMap <= result, oValid=1. Go to WAIT_SOF if iEnable=1, else IDLE.
- oValid is high only in the DONE cycle. oMap holds its value between updates.
- iEnable is sampled only in IDLE, WAIT_SOF and DONE. Deasserting it during ACCUM/EVAL does not abort; that frame completes and publishes.
- In WAIT_SOF, deasserting iEnable returns to IDLE.
- A coordinate (0,0) during ACCUM/EVAL is ignored. No restart mid-frame.
- iThresh changes outside the latch cycle have no effect on the current evaluation.
- Window pixels arriving outside ACCUM are not accumulated.
- Reset mid-ACCUM or mid-EVAL: everything returns to reset values; no partial map is published.

Test Plan:
- Uniform frame R=G=B=512, iThresh=500, iEnable=1 from reset → oValid pulses once per frame; oMap=64'hFFFF_FFFF_FFFF_FFFF; oValid rises 64+1 cycles after (0,598).
- Same frame with iThresh=513 → oMap=0. iThresh=512 → all ones (equality counts as occupied).
- Cell (r=2,c=5) window set to 1023, all else 0, iThresh=1000 → oMap = 64'h1 << 21 exactly.
- Pixel at x=GRID_LEFT+SAMP_OFS_H-1 and x=+32 (just outside window) set to 1023, interior 0, iThresh=1 → bit stays 0 (boundary exclusion).
- Drop iEnable mid-ACCUM → current frame still publishes one oValid; no further pulses; state returns to IDLE.
- Assert iRST_N low at EVAL index 30 → oMap=0, oValid=0, oBusy=0 immediately. After release with iEnable=1, the next full frame produces a correct map.
